// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port req/ack arbiter in front of a single-port RAM.
//               Port 0 is the CPU and port 1 is the host loader. Requests are
//               serialised, and addresses at or above MEM_WORDS are rejected
//               with an error flag.
//               The optional build macro MEM_ARBITER_CPU_PRIORITY_EN replaces
//               round-robin arbitration with a fixed priority for port 0.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_WORDS  = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic                  err0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic                  err1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_ACK    = 2'd2;

    localparam logic [ADDR_WIDTH:0] c_MEM_WORDS = (ADDR_WIDTH + 1)'(MEM_WORDS);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_gnt;
    logic                  r_we;
    logic                  r_oob;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;

    logic                  w_take;
    logic                  w_pick1;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_sel_oob;
    logic                  w_ack;
    logic                  w_rd_upd;

    assign w_take = (r_state == c_ST_IDLE) & (req0 | req1);

`ifdef MEM_ARBITER_CPU_PRIORITY_EN
    assign w_pick1 = req1 & ~req0;
`else
    // Last granted port loses a tie; reset value 1 lets port 0 win the first.
    logic r_last_grant;

    assign w_pick1 = req1 & (~req0 | ~r_last_grant);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= 1'b1;
        end else if (w_take) begin
            r_last_grant <= w_pick1;
        end
    end
`endif

    assign w_sel_we    = w_pick1 ? we1    : we0;
    assign w_sel_addr  = w_pick1 ? addr1  : addr0;
    assign w_sel_wdata = w_pick1 ? wdata1 : wdata0;
    assign w_sel_oob   = ({1'b0, w_sel_addr} >= c_MEM_WORDS);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_take) w_state_nxt = c_ST_ACCESS;
            c_ST_ACCESS: w_state_nxt = c_ST_ACK;
            c_ST_ACK:    w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_gnt       <= 1'b0;
            r_we        <= 1'b0;
            r_oob       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_gnt <= w_pick1;
                r_we  <= w_sel_we;
                r_oob <= w_sel_oob;
                // The RAM never sees an out-of-range address
                if (!w_sel_oob) begin
                    r_mem_addr  <= w_sel_addr;
                    r_mem_wdata <= w_sel_wdata;
                end
            end
            if (w_rd_upd && !r_gnt) r_rdata0 <= mem_rdata;
            if (w_rd_upd &&  r_gnt) r_rdata1 <= mem_rdata;
        end
    end

    assign mem_en    = (r_state == c_ST_ACCESS) & ~r_oob;
    assign mem_we    = mem_en & r_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    assign w_ack    = (r_state == c_ST_ACK);
    assign w_rd_upd = w_ack & ~r_we & ~r_oob;
    assign ack0     = w_ack & ~r_gnt;
    assign ack1     = w_ack &  r_gnt;
    assign err0     = ack0 & r_oob;
    assign err1     = ack1 & r_oob;

    // RAM data arrives during the ack cycle, so it is bypassed to the port
    // while the holding register captures it at the end of that cycle.
    assign rdata0 = (w_rd_upd & ~r_gnt) ? mem_rdata : r_rdata0;
    assign rdata1 = (w_rd_upd &  r_gnt) ? mem_rdata : r_rdata1;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-port linear-memory RAM between the `cpu` load/store unit (port 0) and a host/debug loader (port 1). It serialises requests with a round-robin policy, performs bounds checking against the configured memory size, and returns read data and an error flag over a req/ack handshake. It sits between `cpu` and the linear-memory RAM macro; the `cpu` trap logic consumes port-0 `err0`.

## Interface
- `ADDR_WIDTH`, 16: word-address width.
- `DATA_WIDTH`, 64: data width (i64 words).
- `MEM_WORDS`, 4096: implemented words; addresses ≥ `MEM_WORDS` are out of bounds.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req0`/`req1`  in  1  request, held until the matching ack.
- `we0`/`we1`  in  1  1 = write, 0 = read.
- `addr0`/`addr1`  in  ADDR_WIDTH  word address.
- `wdata0`/`wdata1`  in  DATA_WIDTH  write data.
- `ack0`/`ack1`  out  1  one-cycle completion pulse.
- `err0`/`err1`  out  1  out-of-bounds flag, valid with ack.
- `rdata0`/`rdata1`  out  DATA_WIDTH  read data, valid with ack and held until the next ack on that port.
- `mem_en`  out  1  RAM enable.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  ADDR_WIDTH  RAM address.
- `mem_wdata`  out  DATA_WIDTH  RAM write data.
- `mem_rdata`  in  DATA_WIDTH  RAM read data, one cycle after `mem_en`.

## Operation
- States:
  - `IDLE`: samples the requests.
  - `ACCESS`: drives the RAM.
  - `ACK`: registers `mem_rdata` and pulses ack.
- `IDLE`:
  - If any `req` is high, select a winner, latch its `we`/`addr`/`wdata` and port id, then go to `ACCESS`.
  - Otherwise stay in `IDLE`.
- Arbitration:
  - One requester: it wins.
  - Both requesting: the port other than `last_grant` wins.
  - `last_grant` updates on each grant.
- `ACCESS`:
  - In bounds: `mem_en`=1, `mem_we`=latched `we`, `mem_addr`/`mem_wdata` = latched values.
  - Out of bounds: `mem_en`=0 and the error is latched.
  - Always go to `ACK`.
- `ACK`:
  - Pulse `ack` of the granted port.
  - `err` = the out-of-bounds flag.
  - Read, no error: `rdata` updated from `mem_rdata`.
  - Write or error: `rdata` unchanged.
  - Always return to `IDLE`.
- Requesters must deassert `req` in the cycle after `ack`. A `req` still high in `IDLE` is treated as a new request.
- Dropping `req` before ack is illegal. The started access still completes and acks.
- `mem_en`, `mem_we` = 0 outside `ACCESS`.
- `mem_addr`, `mem_wdata` hold their last values outside `ACCESS`.

## Timing
- Reset values:
  - `ack0`/`ack1`/`err0`/`err1` = 0.
  - `rdata0`/`rdata1` = 0.
  - `mem_en`/`mem_we` = 0.
  - `mem_addr`/`mem_wdata` = 0.
  - State = `IDLE`.
  - `last_grant` = 1, so port 0 wins the first tie.
- Latency: `req` sampled at edge N (state `IDLE`) → `mem_en` high during N+1 → `ack` high during N+2.
- Throughput: one access per 3 cycles.
- A simultaneous request is served at the earliest N+3.
- Reset asserted mid-transaction aborts it: no ack, no further RAM write. Requesters re-issue after reset.
- `err` and `ack` are asserted in the same cycle. `err` is 0 whenever `ack` is 0.
- Out-of-bounds writes never assert `mem_we`.

## Configuration
- `MEM_ARBITER_CPU_PRIORITY_EN`:
  - Defined: fixed priority, port 0 (CPU) always wins ties; `last_grant` is unused.
  - Undefined: round-robin as above.
- Single-requester behaviour and latency are identical in both builds.

## Test plan
- Reset → all outputs 0; port-0 write addr 0x0010, wdata 0x1122334455667788 → `mem_we`=1 two edges after req, `ack0` after three, `err0`=0.
- Port-1 read of addr 0x0010 after that write → `ack1` with `rdata1`=0x1122334455667788; `rdata0` unchanged.
- `req0` and `req1` high from reset, re-issued after each ack → grant order 0,1,0,1. With `MEM_ARBITER_CPU_PRIORITY_EN` → 0,0,0 while `req0` is held.
- Port-0 read addr 4096 (`MEM_WORDS`) → `mem_en` never asserted, `ack0`=1 and `err0`=1 in the same cycle, `rdata0` unchanged.
- `reset` driven low in the `ACCESS` cycle of a port-1 write → no `ack1`, `mem_we`=0 immediately; after release the re-issued request completes in 3 cycles.
- Port-0 out-of-bounds write addr 0xFFFF → `mem_we` stays 0; a subsequent read of addr 0x0FFF returns its previous content.
